// File: rtl/grayscaler.sv
// Purpose: packs the R,G,B byte stream into pixels and emits an 8-bit luma per pixel plus a frame-done strobe.
// Latency: gray_valid is high two cycles after the B byte is captured; at best 5 cycles per pixel.
// Backpressure: pause is high during compute/output; a valid byte arriving then is dropped and sets sticky overrun.
module grayscaler #(
    parameter int N = 450,
    parameter int M = 450
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gray_enable,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       pause,
    output logic [7:0] gray_out,
    output logic       gray_valid,
    output logic       gray_done,
    output logic       overrun
);

    localparam int TOTAL = N * M;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        COMPUTE = 3'd2,
        OUTPUT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       r_q;
    logic [7:0]       g_q;
    logic [7:0]       b_q;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] pix_cnt;
    logic [15:0]      sum;
    logic [15:0]      sum_nxt;
    logic             unused_sum_lo;

    // Luma weights sum to 256, so the top byte of the weighted sum is the gray level.
    always_comb begin
        sum_nxt = ({8'd0, r_q} * 16'd77) + ({8'd0, g_q} * 16'd150) + ({8'd0, b_q} * 16'd29);
    end

    // The gray byte is the top half of the held sum, so it keeps its value between strobes.
    assign gray_out      = sum[15:8];
    assign unused_sum_lo = ^sum[7:0];

    // Frame FSM: byte capture, weighted sum, strobes and flow control, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
            byte_idx   <= 2'd0;
            pix_cnt    <= '0;
            sum        <= 16'd0;
            pause      <= 1'b0;
            gray_valid <= 1'b0;
            gray_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            gray_valid <= 1'b0;
            gray_done  <= 1'b0;
            if (!gray_enable && (state != IDLE)) begin
                // Abort: partial pixel and count are thrown away when IDLE clears them.
                state <= IDLE;
                pause <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        byte_idx <= 2'd0;
                        pix_cnt  <= '0;
                        overrun  <= 1'b0;
                        pause    <= 1'b0;
                        if (gray_enable) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (data_valid) begin
                            case (byte_idx)
                                2'd0: begin
                                    r_q      <= data_in;
                                    byte_idx <= 2'd1;
                                end
                                2'd1: begin
                                    g_q      <= data_in;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    b_q      <= data_in;
                                    byte_idx <= 2'd0;
                                    state    <= COMPUTE;
                                    pause    <= 1'b1;
                                end
                            endcase
                        end
                    end
                    COMPUTE: begin
                        sum        <= sum_nxt;
                        gray_valid <= 1'b1;
                        state      <= OUTPUT;
                        if (data_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    OUTPUT: begin
                        pause <= 1'b0;
                        if (data_valid) begin
                            overrun <= 1'b1;
                        end
                        if (pix_cnt == LAST_PIX) begin
                            state     <= DONE;
                            gray_done <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                            state   <= CAPTURE;
                        end
                    end
                    DONE: begin
                        // A new frame always starts with one IDLE cycle to clear counters.
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        pause <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/grayscaler.md
# grayscaler

Downstream consumer of the RGB frame store: receives the R, G, B byte stream (plus valid) from the RGB R/W memory and packs each byte triple into a pixel. It computes an 8-bit luma value per pixel and throttles the memory with `pause` while computing. It then presents the gray byte with a one-cycle valid strobe, and reports frame completion to the controller.

## Interface
Parameters:
- `N`, 450, frame width in pixels
- `M`, 450, frame height in pixels

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  external asynchronous active-low reset
- `gray_enable`  in  1  controller enable; 0 aborts and holds block in IDLE
- `data_in`  in  8  RGB byte stream from memory, order R, G, B per pixel
- `data_valid`  in  1  high when `data_in` carries a valid byte; connected to memory valid
- `pause`  out  1  high tells memory to hold its read address and stop presenting bytes
- `gray_out`  out  8  gray pixel value
- `gray_valid`  out  1  one-cycle strobe, `gray_out` valid
- `gray_done`  out  1  one-cycle strobe after the last pixel of the frame
- `overrun`  out  1  sticky; a valid byte arrived while `pause` was high

## Operation
- State machine: IDLE, CAPTURE, COMPUTE, OUTPUT, DONE. All outputs are registered or decoded from state only (Moore).
- IDLE:
  - Byte index and pixel counter are cleared to 0. `overrun` is cleared.
  - Go to CAPTURE when `gray_enable`=1.
- CAPTURE:
  - In each cycle with `data_valid`=1, store `data_in` into the R, G or B register selected by byte index 0, 1 or 2, then increment the byte index.
  - When byte index 2 is stored, reset the index to 0 and go to COMPUTE.
  - `data_valid`=0 inserts idle cycles with no state change.
- COMPUTE: `sum` (16-bit) <= R*77 + G*150 + B*29. Then go to OUTPUT. The maximum is 65280, so no overflow occurs.
- OUTPUT:
  - `gray_out` <= `sum[15:8]` (truncation, no rounding). `gray_valid`=1 for this cycle.
  - If pixel counter = N*M-1, go to DONE. Otherwise increment the counter and go to CAPTURE.
- DONE: `gray_done`=1 for one cycle, then go to IDLE.
- `pause` = 1 exactly in COMPUTE and OUTPUT. It is 0 in IDLE, CAPTURE and DONE.
- A byte with `data_valid`=1 while in COMPUTE or OUTPUT is dropped and sets `overrun`=1. `overrun` stays set until IDLE or reset.
- Pixel counter width: ceil(log2(N*M)) bits, which is 18 for the defaults.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `pause`=0, `gray_out`=8'h00, `gray_valid`=0, `gray_done`=0, `overrun`=0; R, G, B, `sum`, byte index and pixel counter are 0.
- Latency: the B byte is captured at edge t. COMPUTE is active in cycle t+1 and OUTPUT in cycle t+2. `gray_valid` is high in the cycle after edge t+1.
- `pause` rises in the cycle after the B capture edge. The upstream memory must hold its data for those 2 cycles.
- Minimum throughput: 5 cycles per pixel (3 capture, 1 compute, 1 output).
- `gray_out` holds its last value between strobes.
- `gray_enable` falling in any non-IDLE state: the next state is IDLE.
  - `pause`, `gray_valid` and `gray_done` go low on that edge.
  - The partial pixel and pixel count are discarded; no `gray_done` is issued.
- `gray_enable` high in DONE: the block still passes through IDLE for one cycle before starting a new frame.
- Last pixel: `gray_valid` in cycle t+2, `gray_done` in cycle t+3, IDLE in t+4.
- Reset asserted mid-frame: all outputs return to their reset values immediately, with no partial strobe.

## Test plan
- Reset mid-COMPUTE: `pause` drops to 0 asynchronously; no `gray_valid` or `gray_done` follows; outputs read reset values.
- Single pixels, back-to-back `data_valid`:
  - (255,255,255) -> `gray_out`=255
  - (100,0,0) -> 30
  - (0,200,0) -> 117
  - (0,0,200) -> 22
  - (10,20,30) -> 18
  - Each `gray_valid` arrives 2 cycles after the B capture edge; `pause` is high for exactly 2 cycles.
- Gapped stream: insert `data_valid`=0 cycles between R, G and B of (10,20,30) -> same result 18; byte ordering is preserved.
- N=M=2 frame, 12 bytes: exactly 4 `gray_valid` pulses, then `gray_done` high for 1 cycle in the cycle after the 4th; state returns to IDLE.
- Overrun: drive `data_valid`=1 during COMPUTE -> byte dropped, `overrun`=1 sticky, next pixel still assembled from the following 3 valid bytes.
- Abort: drop `gray_enable` after 1 pixel plus 2 bytes, then re-enable -> counters restart; a fresh 4-pixel frame (N=M=2) produces 4 strobes and `gray_done`.
